// File: rtl/keyed_dac_modulator.sv
// rtl/keyed_dac_modulator.sv - byte FIFO + symbol serialiser keying a DDS carrier (OOK/BPSK) onto an offset-binary DAC
// Optional feature macro: PREAMBLE_EN (sends an 8'hAA preamble on each IDLE -> busy transition)
module keyed_dac_modulator #(
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic signed [CW-1:0]      carrier,
  input  logic                      mode,
  input  logic [DIV_W-1:0]          sym_div,
  output logic [DW-1:0]             dac_data,
  output logic                      busy,
  output logic                      bit_stb,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SH = DW - CW;
  localparam logic [DW-1:0]        MID  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [CW-1:0] CMIN = {1'b1, {(CW-1){1'b0}}};
  localparam logic signed [CW-1:0] CMAX = ~CMIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
`ifdef PREAMBLE_EN
    , PRE = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             ready_q;
  logic [7:0]       shreg_q;
  logic             mode_q;
  logic [DIV_W-1:0] div_q, sym_q;
  logic [2:0]       bit_q;
  logic [DW-1:0]    dac_q, dac_d;

  logic             pop, push, full, sending, sym_wrap, byte_done, cur_bit;
  logic signed [CW-1:0] neg_c, key_c;
  logic [DW-1:0]    s_w;

  assign pop      = (state_q == LOAD);
  assign full     = (level_q == LW'(DEPTH));
  // A pop in the same clock frees a slot, so a full FIFO still takes a write during LOAD.
  assign wr_ready = ready_q & (~full | pop);
  assign push     = wr_valid & wr_ready;
`ifdef PREAMBLE_EN
  assign sending  = (state_q == SHIFT) || (state_q == PRE);
`else
  assign sending  = (state_q == SHIFT);
`endif
  assign sym_wrap  = (sym_q == div_q);
  assign byte_done = sending & sym_wrap & (bit_q == 3'd7);
  assign cur_bit   = MSB_FIRST ? shreg_q[3'd7 - bit_q] : shreg_q[bit_q];

  assign busy     = (state_q != IDLE);
  assign bit_stb  = sending & (sym_q == '0);
  assign level    = level_q;
  assign dac_data = dac_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
`ifdef PREAMBLE_EN
          state_d = PRE;
`else
          state_d = LOAD;
`endif
        end
      end
      LOAD:  state_d = SHIFT;
      SHIFT: if (byte_done) state_d = (level_q != '0) ? LOAD : IDLE;
`ifdef PREAMBLE_EN
      PRE:   if (byte_done) state_d = LOAD;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      mode_q  <= 1'b0;
      div_q   <= '0;
      sym_q   <= '0;
      bit_q   <= '0;
    end else if (state_q == LOAD) begin
      shreg_q <= mem_q[rd_ptr_q];
      mode_q  <= mode;
      div_q   <= sym_div;
      sym_q   <= '0;
      bit_q   <= '0;
    end
`ifdef PREAMBLE_EN
    else if (state_q == IDLE && level_q != '0) begin
      shreg_q <= 8'hAA;
      mode_q  <= mode;
      div_q   <= sym_div;
      sym_q   <= '0;
      bit_q   <= '0;
    end
`endif
    else if (sending) begin
      if (sym_wrap) begin
        sym_q <= '0;
        bit_q <= bit_q + 3'd1;
      end else begin
        sym_q <= sym_q + DIV_W'(1);
      end
    end
  end

  // Negating the most negative carrier would overflow, so it clips to full-scale positive.
  always_comb begin
    neg_c = (carrier == CMIN) ? CMAX : -carrier;
    key_c = '0;
    if (cur_bit)     key_c = carrier;
    else if (mode_q) key_c = neg_c;
    s_w   = DW'(key_c) << SH;
    dac_d = sending ? {~s_w[DW-1], s_w[DW-2:0]} : MID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dac_q <= MID;
    else       dac_q <= dac_d;
  end

endmodule
